phy_rx_lanes: RTL and testbench
===============================

// Module: phy_rx_lanes
// PURPOSE
//  Receive side of the 2-lane serial PHY link. Deserializes lanes data_in_0/data_in_1
//  (1 bit per clk_32f, MSB first), finds byte alignment on the COM idle symbol (8'hBC),
//  un-stripes byte pairs and rebuilds 32-bit words for the core.
//  Sits opposite PHY_TX; lane 0 carries bytes [31:24] then [15:8], lane 1 carries [23:16] then [7:0].
// PARAMETERS
//  COM          8'hBC  idle/alignment symbol; never legal as a data byte
//  ALIGN_COUNT  4      consecutive COM pairs (including the locking one) required to go ACTIVE
// PORTS
//  clk_32f    in   1   bit-rate clock; all logic on rising edge
//  reset      in   1   asynchronous, active-low reset
//  data_in_0  in   1   serial lane 0
//  data_in_1  in   1   serial lane 1
//  data_out   out  32  reassembled word, held until next word
//  valid_out  out  1   one-cycle strobe, data_out valid
//  active_out out  1   link aligned and accepting data
//  err_out    out  1   one-cycle strobe on protocol error
//  err_count  out  8   saturating error count (only with PHY_RX_ERRCNT_EN)
// BEHAVIOUR
//  - Reset (reset==0, async): all outputs 0, state SEARCH, shift regs 0, bit_cnt 0, bc_cnt 0, half flag clear.
//  - Per lane: 8-bit shift reg sr_n <= {sr_n[6:0], data_in_n} every cycle; bit_cnt 0..7 wraps.
//  - Byte boundary = edge where bit_cnt==7; evaluated byte is {sr_n[6:0], data_in_n}.
//  - FSM SEARCH: every cycle compare {sr0[6:0],data_in_0}==COM AND {sr1[6:0],data_in_1}==COM;
//    on match: bit_cnt<=0 (phase locked), bc_cnt<=1, go ALIGN. Any bit offset must lock.
//  - ALIGN: at each boundary, both COM -> bc_cnt+1; when bc_cnt reaches ALIGN_COUNT -> ACTIVE,
//    active_out<=1 on that edge. Any non-COM byte on either lane -> SEARCH, bc_cnt<=0.
//  - ACTIVE, at each boundary:
//    both COM: idle; if half flag set -> err_out pulse, discard high half, clear flag.
//    both data, flag clear: store {b0,b1} as data[31:16], set flag.
//    both data, flag set: data_out<={hi,b0,b1}, valid_out pulse, clear flag.
//    one COM one data: err_out pulse, discard half, active_out<=0, go SEARCH.
//  - Latency: valid_out high for exactly one cycle, on the edge sampling the LSB of the low pair
//    (registered output visible the following cycle). data_out unchanged between strobes.
//  - Back-to-back words: one valid_out every 16 clk_32f, no gap needed.
//  - valid_out and err_out never both high. Idle runs of any length keep active_out=1.
//  - Reset mid-word: partial word lost, no valid_out, realignment required.
// CONFIGURATION
//  PHY_RX_ERRCNT_EN defined: port err_count present; increments on every err_out pulse,
//    saturates at 8'hFF, cleared only by reset.
//  Undefined: port and counter absent; all other behaviour identical.
// TESTING
//  1 reset low 3 cycles, lanes idle 0 -> all outputs 0, active_out stays 0.
//  2 COM x4 on both lanes at bit offset 3 -> active_out=1 at boundary of 4th COM; no valid_out.
//  3 active, send 0xDEADBEEF (lane0 DE,BE; lane1 AD,EF) -> one valid_out, data_out=32'hDEADBEEF.
//  4 words 0x12345678,0xA5A5_0F0F back-to-back -> valid_out 16 cycles apart, both correct.
//  5 high pair then COM pair -> err_out 1 cycle, no valid_out, active_out stays 1;
//    lane0 data/lane1 COM -> err_out, active_out=0, realign with 4 COM.
//  6 reset asserted mid-word -> outputs 0 immediately; with PHY_RX_ERRCNT_EN 300 errors -> err_count=8'hFF.

Source files
------------

// File: rtl/phy_rx_lanes.sv
// ============================================================================
// Module      : phy_rx_lanes
// Description : 2-lane serial PHY receiver. Deserializes both lanes, aligns on
//               COM pairs and rebuilds 32-bit words. Optional saturating error
//               counter port enabled by the PHY_RX_ERRCNT_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module phy_rx_lanes #(
   parameter logic [7:0] COM         = 8'hBC,
   parameter int         ALIGN_COUNT = 4
) (
   input  logic        clk_32f,
   input  logic        reset,
   input  logic        data_in_0,
   input  logic        data_in_1,
   output logic [31:0] data_out,
   output logic        valid_out,
   output logic        active_out,
   output logic        err_out
`ifdef PHY_RX_ERRCNT_EN
   ,
   output logic [7:0]  err_count
`endif
);

   localparam int         c_BC_W    = $clog2(ALIGN_COUNT + 1);
   localparam logic [1:0] c_SEARCH  = 2'd0;
   localparam logic [1:0] c_ALIGN   = 2'd1;
   localparam logic [1:0] c_ACTIVE  = 2'd2;

   logic [1:0]        r_state;
   logic [1:0]        w_state_nxt;
   logic [6:0]        r_sr0;
   logic [6:0]        r_sr1;
   logic [2:0]        r_bit_cnt;
   logic [c_BC_W-1:0] r_bc_cnt;
   logic              r_half;
   logic [15:0]       r_hi;
   logic [31:0]       r_data;
   logic              r_valid;
   logic              r_active;
   logic              r_err;

   logic [7:0]        w_b0;
   logic [7:0]        w_b1;
   logic              w_com0;
   logic              w_com1;
   logic              w_both_com;
   logic              w_both_data;
   logic              w_bnd;
   logic [c_BC_W-1:0] w_bc_inc;
   logic              w_align_done;

   logic [2:0]        w_bit_cnt_nxt;
   logic [c_BC_W-1:0] w_bc_cnt_nxt;
   logic              w_half_nxt;
   logic [15:0]       w_hi_nxt;
   logic [31:0]       w_data_nxt;
   logic              w_valid_nxt;
   logic              w_active_nxt;
   logic              w_err_nxt;

   // Evaluated byte includes the bit arriving on this edge.
   assign w_b0         = {r_sr0, data_in_0};
   assign w_b1         = {r_sr1, data_in_1};
   assign w_com0       = (w_b0 == COM);
   assign w_com1       = (w_b1 == COM);
   assign w_both_com   = w_com0 & w_com1;
   assign w_both_data  = ~w_com0 & ~w_com1;
   assign w_bnd        = (r_bit_cnt == 3'd7);
   assign w_bc_inc     = r_bc_cnt + c_BC_W'(1);
   assign w_align_done = (w_bc_inc == c_BC_W'(ALIGN_COUNT));

   always_ff @(posedge clk_32f or negedge reset) begin
      if (!reset) begin
         r_state <= c_SEARCH;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_SEARCH: begin
            if (w_both_com) begin
               w_state_nxt = c_ALIGN;
            end
         end
         c_ALIGN: begin
            if (w_bnd) begin
               if (!w_both_com) begin
                  w_state_nxt = c_SEARCH;
               end else if (w_align_done) begin
                  w_state_nxt = c_ACTIVE;
               end
            end
         end
         c_ACTIVE: begin
            if (w_bnd && (w_com0 != w_com1)) begin
               w_state_nxt = c_SEARCH;
            end
         end
         default: w_state_nxt = c_SEARCH;
      endcase
   end

   always_comb begin
      w_bit_cnt_nxt = r_bit_cnt + 3'd1;
      w_bc_cnt_nxt  = r_bc_cnt;
      w_half_nxt    = r_half;
      w_hi_nxt      = r_hi;
      w_data_nxt    = r_data;
      w_valid_nxt   = 1'b0;
      w_active_nxt  = r_active;
      w_err_nxt     = 1'b0;
      case (r_state)
         c_SEARCH: begin
            if (w_both_com) begin
               w_bit_cnt_nxt = 3'd0;
               w_bc_cnt_nxt  = c_BC_W'(1);
            end
         end
         c_ALIGN: begin
            if (w_bnd) begin
               if (w_both_com) begin
                  w_bc_cnt_nxt = w_bc_inc;
                  if (w_align_done) begin
                     w_active_nxt = 1'b1;
                  end
               end else begin
                  w_bc_cnt_nxt = '0;
               end
            end
         end
         c_ACTIVE: begin
            if (w_bnd) begin
               if (w_both_com) begin
                  // Idle between the two halves of a word is a protocol error.
                  if (r_half) begin
                     w_err_nxt  = 1'b1;
                     w_half_nxt = 1'b0;
                  end
               end else if (w_both_data) begin
                  if (!r_half) begin
                     w_hi_nxt   = {w_b0, w_b1};
                     w_half_nxt = 1'b1;
                  end else begin
                     w_data_nxt  = {r_hi, w_b0, w_b1};
                     w_valid_nxt = 1'b1;
                     w_half_nxt  = 1'b0;
                  end
               end else begin
                  w_err_nxt    = 1'b1;
                  w_half_nxt   = 1'b0;
                  w_active_nxt = 1'b0;
                  w_bc_cnt_nxt = '0;
               end
            end
         end
         default: begin
            w_active_nxt = 1'b0;
            w_half_nxt   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_32f or negedge reset) begin
      if (!reset) begin
         r_sr0     <= '0;
         r_sr1     <= '0;
         r_bit_cnt <= '0;
         r_bc_cnt  <= '0;
         r_half    <= 1'b0;
         r_hi      <= '0;
         r_data    <= '0;
         r_valid   <= 1'b0;
         r_active  <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_sr0     <= w_b0[6:0];
         r_sr1     <= w_b1[6:0];
         r_bit_cnt <= w_bit_cnt_nxt;
         r_bc_cnt  <= w_bc_cnt_nxt;
         r_half    <= w_half_nxt;
         r_hi      <= w_hi_nxt;
         r_data    <= w_data_nxt;
         r_valid   <= w_valid_nxt;
         r_active  <= w_active_nxt;
         r_err     <= w_err_nxt;
      end
   end

   assign data_out   = r_data;
   assign valid_out  = r_valid;
   assign active_out = r_active;
   assign err_out    = r_err;

`ifdef PHY_RX_ERRCNT_EN
   logic [7:0] r_err_count;

   // Counter moves on the same edge that raises err_out.
   always_ff @(posedge clk_32f or negedge reset) begin
      if (!reset) begin
         r_err_count <= '0;
      end else if (w_err_nxt && (r_err_count != 8'hFF)) begin
         r_err_count <= r_err_count + 8'd1;
      end
   end

   assign err_count = r_err_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_phy_rx_lanes.sv
// ============================================================================
// Module      : tb_phy_rx_lanes
// Description : Self-checking bench for phy_rx_lanes with a byte-pair level
//               reference model; honours PHY_RX_ERRCNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_phy_rx_lanes;

   localparam logic [7:0] c_COM = 8'hBC;

   logic        clk_32f = 1'b0;
   logic        reset;
   logic        data_in_0;
   logic        data_in_1;
   logic [31:0] data_out;
   logic        valid_out;
   logic        active_out;
   logic        err_out;
`ifdef PHY_RX_ERRCNT_EN
   logic [7:0]  err_count;
`endif

   int total = 0;
   int bad   = 0;

   // Link model kept at byte-pair granularity
   int          m_st;      // 0 searching, 1 aligning, 2 active
   int          m_cnt;
   bit          m_half;
   logic [15:0] m_hi;
   logic [31:0] m_data;
   bit          m_active;
   int          m_errcnt;
   bit          e_valid;
   bit          e_err;

   phy_rx_lanes dut (
      .clk_32f    (clk_32f),
      .reset      (reset),
      .data_in_0  (data_in_0),
      .data_in_1  (data_in_1),
      .data_out   (data_out),
      .valid_out  (valid_out),
      .active_out (active_out),
      .err_out    (err_out)
`ifdef PHY_RX_ERRCNT_EN
      ,
      .err_count  (err_count)
`endif
   );

   always #5 clk_32f = ~clk_32f;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_st = 0; m_cnt = 0; m_half = 0; m_hi = '0; m_data = '0;
      m_active = 0; m_errcnt = 0; e_valid = 0; e_err = 0;
   endtask

   task automatic model_pair(input logic [7:0] b0, input logic [7:0] b1);
      bit c0, c1;
      c0 = (b0 == c_COM);
      c1 = (b1 == c_COM);
      if (m_st == 0) begin
         if (c0 && c1) begin m_st = 1; m_cnt = 1; end
      end else if (m_st == 1) begin
         if (c0 && c1) begin
            m_cnt++;
            if (m_cnt == 4) begin m_st = 2; m_active = 1; end
         end else begin
            m_st = 0; m_cnt = 0;
         end
      end else begin
         if (c0 && c1) begin
            if (m_half) begin e_err = 1; m_half = 0; end
         end else if (!c0 && !c1) begin
            if (m_half) begin m_data = {m_hi, b0, b1}; e_valid = 1; m_half = 0; end
            else begin m_hi = {b0, b1}; m_half = 1; end
         end else begin
            e_err = 1; m_half = 0; m_active = 0; m_st = 0; m_cnt = 0;
         end
      end
      if (e_err && m_errcnt < 255) m_errcnt++;
   endtask

   task automatic check_outputs();
      chk("valid_out", {31'd0, valid_out}, {31'd0, e_valid});
      chk("err_out", {31'd0, err_out}, {31'd0, e_err});
      chk("active_out", {31'd0, active_out}, {31'd0, m_active});
      chk("data_out", data_out, m_data);
`ifdef PHY_RX_ERRCNT_EN
      chk("err_count", {24'd0, err_count}, m_errcnt);
`endif
   endtask

   // Shift out the top n bits of each byte, MSB first; a full pair updates the model.
   task automatic send_bits(input logic [7:0] b0, input logic [7:0] b1, input int n, input bit upd);
      for (int i = 7; i >= 8 - n; i--) begin
         data_in_0 = b0[i];
         data_in_1 = b1[i];
         @(posedge clk_32f);
         #1;
         e_valid = 0;
         e_err   = 0;
         if (upd && i == 0) model_pair(b0, b1);
         check_outputs();
      end
   endtask

   task automatic send_pair(input logic [7:0] b0, input logic [7:0] b1);
      send_bits(b0, b1, 8, 1'b1);
   endtask

   task automatic send_word(input logic [31:0] w);
      send_pair(w[31:24], w[23:16]);
      send_pair(w[15:8], w[7:0]);
   endtask

   task automatic idle_zero(input int n);
      for (int k = 0; k < n; k++) send_bits(8'h00, 8'h00, 1, 1'b0);
   endtask

   task automatic align4();
      for (int k = 0; k < 4; k++) send_pair(c_COM, c_COM);
   endtask

   function automatic logic [7:0] rnd_data();
      logic [7:0] b;
      do b = 8'($urandom_range(0, 255)); while (b == c_COM);
      return b;
   endfunction

   task automatic async_reset();
      reset = 1'b0;
      data_in_0 = 1'b0;
      data_in_1 = 1'b0;
      #1;
      model_reset();
      check_outputs();
      @(posedge clk_32f);
      #1;
      check_outputs();
      reset = 1'b1;
   endtask

   initial begin
      int r;
      model_reset();
      reset = 1'b0;
      data_in_0 = 1'b0;
      data_in_1 = 1'b0;

      // Held in reset with idle lanes
      repeat (3) begin
         @(posedge clk_32f);
         #1;
         check_outputs();
      end
      reset = 1'b1;

      // Lock at bit offset 3
      idle_zero(3);
      align4();
      chk("active_after_align", {31'd0, active_out}, 32'd1);

      send_word(32'hDEADBEEF);
      chk("deadbeef", data_out, 32'hDEADBEEF);

      send_word(32'h12345678);
      send_word(32'hA5A50F0F);
      chk("b2b_second", data_out, 32'hA5A50F0F);

      // High half followed by idle
      send_pair(8'h11, 8'h22);
      send_pair(c_COM, c_COM);
      chk("active_after_half_err", {31'd0, active_out}, 32'd1);

      // Mixed pair drops the link
      send_pair(8'h5A, c_COM);
      chk("active_after_mixed", {31'd0, active_out}, 32'd0);
      idle_zero(8 + $urandom_range(0, 7));
      align4();
      send_word(32'hCAFEF00D);

      // Randomized traffic
      for (int it = 0; it < 60; it++) begin
         r = $urandom_range(0, 9);
         if (r <= 5) begin
            send_word({rnd_data(), rnd_data(), rnd_data(), rnd_data()});
         end else if (r <= 7) begin
            send_pair(c_COM, c_COM);
         end else if (r == 8) begin
            send_pair(rnd_data(), rnd_data());
            send_pair(c_COM, c_COM);
         end else begin
            if ($urandom_range(0, 1) == 1) send_pair(rnd_data(), c_COM);
            else send_pair(c_COM, rnd_data());
            idle_zero(8 + $urandom_range(0, 7));
            align4();
         end
      end

      // Reset in the middle of a word
      send_pair(8'h01, 8'h02);
      send_bits(8'h03, 8'h04, 3, 1'b0);
      async_reset();
      idle_zero(10);
      chk("active_after_reset", {31'd0, active_out}, 32'd0);
      idle_zero($urandom_range(0, 7));
      align4();
      send_word(32'h0BADC0DE);

`ifdef PHY_RX_ERRCNT_EN
      for (int k = 0; k < 300; k++) begin
         send_pair(rnd_data(), rnd_data());
         send_pair(c_COM, c_COM);
      end
      chk("err_count_sat", {24'd0, err_count}, 32'h0000_00FF);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      bad++;
      $display("FAIL timeout observed=running expected=finished");
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
